// File: rtl/tt_logic_engine.sv
// Reprogrammable truth-table engine: N_OUT tables of N_IN inputs evaluated on a registered path,
// reloaded over a valid/ready port, with a self-check sweep that signs each table back.
module tt_logic_engine #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter logic [(1 << N_IN)-1:0] TT_INIT = 16'h1D95
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_IN-1:0]               in,
  output logic [N_OUT-1:0]              out,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2:0]                    cfg_ch,
  input  logic [(1 << N_IN)-1:0]        cfg_data,
  output logic                          cfg_err,
  input  logic                          sweep_start,
  input  logic [N_OUT*(1 << N_IN)-1:0]  sweep_exp,
  output logic                          sweep_busy,
  output logic                          sweep_done,
  output logic                          sweep_pass,
  output logic [N_IN-1:0]               sweep_fidx
);

  localparam int unsigned TTW = 1 << N_IN;
  localparam logic [3:0]  N_OUT_W = 4'(N_OUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef logic [N_IN-1:0] idx_t;
  typedef logic [TTW-1:0]  tt_t;

  localparam idx_t IDX_MAX = '1;

  logic [1:0]           state_q, state_d;
  tt_t                  tt_q  [N_OUT];
  tt_t                  tt_d  [N_OUT];
  tt_t                  sig_q [N_OUT];
  tt_t                  sig_d [N_OUT];
  idx_t                 idx_q, idx_d;
  idx_t                 fidx_q, fidx_d;
  logic [N_OUT-1:0]     out_q, out_d;
  logic [N_OUT*TTW-1:0] exp_q, exp_d;
  logic [N_OUT*TTW-1:0] sig_flat;
  tt_t                  diff;
  logic                 pass_q, pass_d;
  logic                 err_q, err_d;
  logic                 xfer, bad_ch;

  always_comb begin
    state_d  = state_q;
    tt_d     = tt_q;
    sig_d    = sig_q;
    idx_d    = idx_q;
    fidx_d   = fidx_q;
    out_d    = out_q;
    exp_d    = exp_q;
    pass_d   = pass_q;
    err_d    = 1'b0;
    sig_flat = '0;
    diff     = '0;
    xfer     = cfg_valid && (state_q == IDLE);
    bad_ch   = {1'b0, cfg_ch} >= N_OUT_W;

    case (state_q)
      IDLE: begin
        for (int c = 0; c < N_OUT; c++) out_d[c] = tt_q[c][in];
        if (xfer) begin
          // Out-of-range channels match no table and are simply dropped.
          for (int c = 0; c < N_OUT; c++) begin
            if (cfg_ch == 3'(c)) tt_d[c] = cfg_data;
          end
          err_d = bad_ch;
        end else if (sweep_start) begin
          state_d = SWEEP;
          exp_d   = sweep_exp;
          idx_d   = '0;
          pass_d  = 1'b0;
          fidx_d  = '0;
          for (int c = 0; c < N_OUT; c++) sig_d[c] = '0;
        end
      end
      SWEEP: begin
        for (int c = 0; c < N_OUT; c++) sig_d[c][idx_q] = tt_q[c][idx_q];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_MAX) begin
          state_d = DONE;
          // Judge on the completed signature so the verdict is valid during the done pulse.
          for (int c = 0; c < N_OUT; c++) begin
            sig_flat[c*TTW +: TTW] = sig_d[c];
            diff = diff | (sig_d[c] ^ exp_q[c*TTW +: TTW]);
          end
          pass_d = (sig_flat == exp_q);
          fidx_d = '0;
          for (int i = TTW - 1; i >= 0; i--) begin
            if (diff[i]) fidx_d = idx_t'(i);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int c = 0; c < N_OUT; c++) begin
        tt_q[c]  <= TT_INIT;
        sig_q[c] <= '0;
      end
      idx_q  <= '0;
      fidx_q <= '0;
      out_q  <= '0;
      exp_q  <= '0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      fidx_q  <= fidx_d;
      out_q   <= out_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign out        = out_q;
  assign cfg_ready  = (state_q == IDLE);
  assign cfg_err    = err_q;
  assign sweep_busy = (state_q == SWEEP);
  assign sweep_done = (state_q == DONE);
  assign sweep_pass = pass_q;
  assign sweep_fidx = fidx_q;

endmodule

// File: tb/tb_tt_logic_engine.sv
// Directed bench for tt_logic_engine: table-driven eval/config vectors plus hand-written
// sequences for sweep timing, mismatch reporting, config priority and mid-sweep reset.
module tb_tt_logic_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_s = '0;
  logic [1:0]  out_s;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_ch = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_err;
  logic        sweep_start = 1'b0;
  logic [31:0] sweep_exp = '0;
  logic        sweep_busy;
  logic        sweep_done;
  logic        sweep_pass;
  logic [3:0]  sweep_fidx;

  int n_chk  = 0;
  int n_fail = 0;

  tt_logic_engine #(
    .N_IN   (4),
    .N_OUT  (2),
    .TT_INIT(16'h1D95)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_s),
    .out        (out_s),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .sweep_start(sweep_start),
    .sweep_exp  (sweep_exp),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .sweep_pass (sweep_pass),
    .sweep_fidx (sweep_fidx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a sweep, follow it through DONE and back to IDLE.
  task automatic run_sweep(input logic [31:0] exp_img, input logic exp_pass,
                           input logic [3:0] exp_fidx, input bit disturb);
    int busy_cnt;
    busy_cnt    = 0;
    sweep_exp   = exp_img;
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    check("start_clears_pass", 32'(sweep_pass), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (sweep_busy && !sweep_done) busy_cnt++;
      if (disturb) begin
        in_s = 4'd1;
        if (i == 3) begin
          cfg_valid = 1'b1;
          cfg_ch    = 3'd0;
          cfg_data  = 16'h0000;
          check("ready_low_in_sweep", 32'(cfg_ready), 32'd0);
        end
        if (i == 10) cfg_valid = 1'b0;
        if (i == 5) sweep_start = 1'b1;
        if (i == 6) sweep_start = 1'b0;
      end
      tick;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("done_pulse", 32'(sweep_done), 32'd1);
    check("busy_off_in_done", 32'(sweep_busy), 32'd0);
    check("ready_low_in_done", 32'(cfg_ready), 32'd0);
    check("sweep_pass", 32'(sweep_pass), 32'(exp_pass));
    check("sweep_fidx", 32'(sweep_fidx), 32'(exp_fidx));
    if (disturb) check("out_held", 32'(out_s), 32'd3);
    tick;
    in_s = 4'd0;
    check("done_one_cycle", 32'(sweep_done), 32'd0);
    check("ready_back", 32'(cfg_ready), 32'd1);
    check("pass_held", 32'(sweep_pass), 32'(exp_pass));
  endtask

  typedef struct {
    logic [3:0]  in;
    logic        cv;
    logic [2:0]  ch;
    logic [15:0] data;
    logic [1:0]  eo;
    logic        ee;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int done_seen;

    // Tables 0x1D95: bits 0..15 = 1,0,1,0, 1,0,0,1, 1,0,1,1, 1,0,0,0
    vecs[0]  = '{4'd0,  1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 3'd0, 16'h0000, 2'b00, 1'b0};
    vecs[2]  = '{4'd2,  1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};
    vecs[3]  = '{4'd3,  1'b0, 3'd0, 16'h0000, 2'b00, 1'b0};
    vecs[4]  = '{4'd7,  1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};
    vecs[5]  = '{4'd15, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0};
    vecs[6]  = '{4'd11, 1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};
    // ch0 <= FFFF; the write edge still evaluates the old table
    vecs[7]  = '{4'd3,  1'b1, 3'd0, 16'hFFFF, 2'b00, 1'b0};
    vecs[8]  = '{4'd3,  1'b0, 3'd0, 16'h0000, 2'b01, 1'b0};
    vecs[9]  = '{4'd13, 1'b0, 3'd0, 16'h0000, 2'b01, 1'b0};
    vecs[10] = '{4'd3,  1'b1, 3'd0, 16'h1D95, 2'b01, 1'b0};
    vecs[11] = '{4'd3,  1'b0, 3'd0, 16'h0000, 2'b00, 1'b0};
    // Out-of-range channel: accepted, dropped, error pulse
    vecs[12] = '{4'd0,  1'b1, 3'd5, 16'h0000, 2'b11, 1'b1};
    vecs[13] = '{4'd0,  1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};
    vecs[14] = '{4'd4,  1'b1, 3'd1, 16'h0000, 2'b11, 1'b0};
    vecs[15] = '{4'd4,  1'b0, 3'd0, 16'h0000, 2'b01, 1'b0};
    vecs[16] = '{4'd4,  1'b1, 3'd1, 16'h1D95, 2'b01, 1'b0};
    vecs[17] = '{4'd4,  1'b0, 3'd0, 16'h0000, 2'b11, 1'b0};

    // Reset defaults
    tick;
    check("rst_out", 32'(out_s), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_busy", 32'(sweep_busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_pass", 32'(sweep_pass), 32'd0);
    check("rst_fidx", 32'(sweep_fidx), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      in_s      = vecs[i].in;
      cfg_valid = vecs[i].cv;
      cfg_ch    = vecs[i].ch;
      cfg_data  = vecs[i].data;
      tick;
      cfg_valid = 1'b0;
      check($sformatf("vec%0d_out", i), 32'(out_s), 32'(vecs[i].eo));
      check($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(vecs[i].ee));
    end

    // Matching sweep, with stalled config, ignored restart and changing inputs during it
    in_s = 4'd0;
    tick;
    run_sweep({16'h1D95, 16'h1D95}, 1'b1, 4'd0, 1'b1);

    // Mismatches: ch1 bit 0, then ch0 bit 15
    run_sweep({16'h1D94, 16'h1D95}, 1'b0, 4'd0, 1'b0);
    run_sweep({16'h1D95, 16'h9D95}, 1'b0, 4'd15, 1'b0);

    // Config beats sweep_start in the same cycle; start is dropped, not queued
    cfg_valid   = 1'b1;
    cfg_ch      = 3'd0;
    cfg_data    = 16'h1D95;
    sweep_start = 1'b1;
    tick;
    cfg_valid   = 1'b0;
    sweep_start = 1'b0;
    check("cfg_priority_busy", 32'(sweep_busy), 32'd0);
    tick;
    check("start_not_queued", 32'(sweep_busy), 32'd0);

    // Mid-sweep reset: ch0 made FFFF first so the revert to 0x1D95 is observable
    cfg_valid = 1'b1;
    cfg_ch    = 3'd0;
    cfg_data  = 16'hFFFF;
    tick;
    cfg_valid = 1'b0;
    in_s      = 4'd1;
    tick;
    tick;
    check("pre_rst_out", 32'(out_s), 32'd1);
    sweep_exp   = {16'h1D95, 16'hFFFF};
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    repeat (7) tick;
    check("pre_rst_busy", 32'(sweep_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(sweep_busy), 32'd0);
    check("mid_rst_out", 32'(out_s), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_done", 32'(sweep_done), 32'd0);
    tick;
    rst       = 1'b0;
    in_s      = 4'd0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done) done_seen++;
      tick;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);
    run_sweep({16'h1D95, 16'h1D95}, 1'b1, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
